pll_mode_sequencer: RTL and testbench
=====================================

# pll_mode_sequencer

Parametrised PLL reconfiguration sequencer that retunes the core's system PLL via its Avalon-MM reconfiguration port when a requested clock mode changes, e.g. native, 60 Hz underclock or bootleg timing. It generalises the per-core fixed two-mode retune logic to N modes with a fractional-K table, input glitch filtering, safe handling of requests arriving mid-sequence, and lock confirmation with timeout. It sits beside the PLL reconfiguration IP in the emu top, clocked from the PLL management clock.

## Interface
- NUM_MODES, 4: number of selectable modes (2..16).
- FRAC_TABLE, all zero: packed NUM_MODES×32-bit fractional-K values; mode m occupies bits [32m+31:32m].
- RESET_MODE, 0: mode the PLL is compiled for; applied after reset without a sequence.
- STABLE_CYCLES, 4: cycles a synchronised request must stay constant before it is accepted.
- GAP_CYCLES, 3: idle cycles between consecutive writes.
- LOCK_MASK, 16: cycles after the start write during which pll_locked is ignored.
- LOCK_TIMEOUT, 65535: maximum cycles from start-write acceptance to lock.
- clk  in  1  management clock.
- reset  in  1  synchronous, active-high reset.
- mode_req  in  MW=$clog2(NUM_MODES)  requested mode; asynchronous to clk.
- mgmt_waitrequest  in  1  Avalon-MM waitrequest from the reconfig IP.
- mgmt_write  out  1  write strobe.
- mgmt_address  out  6  register address.
- mgmt_writedata  out  32  write data.
- pll_locked  in  1  PLL locked; asynchronous.
- busy  out  1  high from sequence start until done or error.
- done  out  1  one-cycle pulse when lock is confirmed.
- error  out  1  one-cycle pulse on lock timeout.
- cur_mode  out  MW  last mode applied.

## Operation
- mode_req and pll_locked each pass through a 2-flop synchroniser. A filter accepts the synchronised request as target once it has been identical for STABLE_CYCLES consecutive cycles. Requests with a value of NUM_MODES or more are never accepted.
- States:
  - IDLE: go to WR_MODE if target != cur_mode. Latch target into active_mode and assert busy.
  - WR_MODE: write address 0, data 0. Then GAP.
  - WR_FRAC: write address 7, data FRAC_TABLE[active_mode]. Then GAP.
  - WR_START: write address 2, data 0. Then WAIT_LOCK.
  - GAP: count GAP_CYCLES, then go to the next write state.
  - WAIT_LOCK: ignore lock for the first LOCK_MASK cycles. After that, a synchronised pll_locked=1 pulses done, sets cur_mode to active_mode and returns to IDLE. Reaching LOCK_TIMEOUT cycles pulses error, still sets cur_mode, and returns to IDLE.
- Write handshake:
  - mgmt_write, mgmt_address and mgmt_writedata are held constant from state entry until a rising edge where mgmt_write=1 and mgmt_waitrequest=0. That edge accepts the write.
  - mgmt_write drops on the following cycle.
- Target changes during a sequence do not disturb it. On return to IDLE the current target is re-evaluated, so the latest request wins and intermediate values are dropped.
- Simultaneous done and target change: done pulses, then a new sequence begins from IDLE on the next cycle.

## Timing
- Reset values: mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, error=0, cur_mode=RESET_MODE. After reset, state=IDLE, target=RESET_MODE, and the filter count is cleared.
- Reset mid-sequence: all outputs return to reset values on the next edge, and an in-flight write is abandoned.
- Request-to-first-write latency: 2 (sync) + STABLE_CYCLES + 1 (IDLE) cycles, with zero waitrequest.
- Total write phase with zero waitrequest: 3 accepted writes + 2×GAP_CYCLES. waitrequest stretches each write by its asserted cycles.
- Timeout counter width is $clog2(LOCK_TIMEOUT+1). It saturates and clears on entry to WAIT_LOCK.
- done and error are mutually exclusive and never both high.

## Structure
- Package pll_seq_pkg holds the state enum and the address constants ADDR_MODE=0, ADDR_FRAC=7 and ADDR_START=2.
- Sub-module pll_req_filter contains the 2-flop sync, the stability counter and the range check, and outputs the target.
- Sequencer FSM and counters live in pll_mode_sequencer.

## Test plan
- NUM_MODES=3, FRAC_TABLE={2748778984, 2977614927, 3639383488} (modes 2,1,0), zero waitrequest. mode_req 0→1 → writes (0,0), (7,2977614927), (2,0) with 3-cycle gaps. pll_locked after 20 cycles → done pulse, cur_mode=1.
- waitrequest high for 5 cycles during the FRAC write → address and data held stable, exactly one accepted write, sequence otherwise unchanged.
- mode_req glitch 0→2→0 lasting 2 cycles → no write issued, busy stays 0.
- Request 2 issued, then 1 issued during WR_FRAC → sequence for 2 completes, then a full sequence for 1 follows. Final cur_mode=1.
- pll_locked held 0 → error after LOCK_TIMEOUT cycles, cur_mode updated, busy drops. pll_locked=1 during the LOCK_MASK window is ignored.
- reset asserted during GAP → next cycle mgmt_write=0, busy=0, cur_mode=RESET_MODE. If mode_req still differs, the sequence re-runs after the filter delay.

Source files
------------

// File: rtl/pll_mode_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_seq_pkg                                                                |
// | Shared types and constants for the PLL mode sequencer: FSM state encoding, |
// | Avalon-MM reconfiguration register addresses and a small address helper.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package pll_seq_pkg;

  localparam int ADDR_W = 6;

  // Reconfiguration IP register map: mode select, fractional K, start.
  localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'd0;
  localparam logic [ADDR_W-1:0] ADDR_FRAC  = 6'd7;
  localparam logic [ADDR_W-1:0] ADDR_START = 6'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_MODE   = 3'd1,
    S_WR_FRAC   = 3'd2,
    S_WR_START  = 3'd3,
    S_GAP       = 3'd4,
    S_WAIT_LOCK = 3'd5
  } seq_state_e;

  // Register address written by each write state.
  function automatic logic [ADDR_W-1:0] write_addr(input seq_state_e s);
    case (s)
      S_WR_FRAC:  return ADDR_FRAC;
      S_WR_START: return ADDR_START;
      default:    return ADDR_MODE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_mode_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_mode_sequencer_if                                                      |
// | Avalon-MM write-only management bus toward the PLL reconfiguration IP.     |
// |   mgmt_write       write strobe            (master -> slave)               |
// |   mgmt_address     6-bit register address  (master -> slave)               |
// |   mgmt_writedata   32-bit write data       (master -> slave)               |
// |   mgmt_waitrequest stall                   (slave -> master)               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface pll_mode_sequencer_if;
  import pll_seq_pkg::*;

  logic              mgmt_write;
  logic [ADDR_W-1:0] mgmt_address;
  logic [31:0]       mgmt_writedata;
  logic              mgmt_waitrequest;

  modport master (
    output mgmt_write,
    output mgmt_address,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_write,
    input  mgmt_address,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );

endinterface
`default_nettype wire

// File: rtl/pll_mode_sequencer_req_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_req_filter                                                             |
// | Synchronises the asynchronous mode request, rejects out-of-range values    |
// | and only accepts a request once it has been stable for STABLE_CYCLES.      |
// |   clk      in   management clock                                          |
// |   reset    in   synchronous active-high reset                             |
// |   mode_req in   raw requested mode (asynchronous)                         |
// |   target   out  accepted mode                                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pll_req_filter #(
  parameter  int NUM_MODES     = 4,
  parameter  int RESET_MODE    = 0,
  parameter  int STABLE_CYCLES = 4,
  localparam int MW            = $clog2(NUM_MODES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [MW-1:0] mode_req,
  output logic [MW-1:0] target
);

  localparam int            SW           = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_C     = SW'(STABLE_CYCLES);
  localparam logic [MW-1:0] RESET_MODE_C = MW'(RESET_MODE);

  logic [MW-1:0] sync1_q, sync1_d;
  logic [MW-1:0] sync2_q, sync2_d;
  logic [MW-1:0] cand_q, cand_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] target_q, target_d;
  logic          in_range;

  always_comb begin
    sync1_d  = mode_req;
    sync2_d  = sync1_q;
    cand_d   = sync2_q;
    target_d = target_q;
    in_range = 32'(sync2_q) < 32'(NUM_MODES);

    // cnt tracks how many consecutive samples equal the candidate,
    // including the current one; it saturates at the threshold.
    if (sync2_q != cand_q) begin
      cnt_d = SW'(1);
    end else if (cnt_q >= STABLE_C) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (cnt_d >= STABLE_C && in_range) begin
      target_d = sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= RESET_MODE_C;
      sync2_q  <= RESET_MODE_C;
      cand_q   <= RESET_MODE_C;
      cnt_q    <= '0;
      target_q <= RESET_MODE_C;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign target = target_q;

endmodule
`default_nettype wire

// File: rtl/pll_mode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_mode_sequencer                                                         |
// | Retunes the system PLL through its reconfiguration port whenever the      |
// | filtered mode request differs from the applied mode: writes mode, frac-K   |
// | and start registers, then waits (masked, with timeout) for lock.          |
// |   clk        in   management clock                                       |
// |   reset      in   synchronous active-high reset                          |
// |   mode_req   in   requested mode (asynchronous)                          |
// |   mgmt       if   Avalon-MM master toward the reconfiguration IP         |
// |   pll_locked in   PLL lock indication (asynchronous)                     |
// |   busy       out  sequence in progress                                   |
// |   done       out  one-cycle pulse, lock confirmed                        |
// |   error      out  one-cycle pulse, lock timeout                          |
// |   cur_mode   out  last mode applied                                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pll_mode_sequencer
  import pll_seq_pkg::*;
#(
  parameter  int                      NUM_MODES     = 4,
  parameter  logic [NUM_MODES*32-1:0] FRAC_TABLE    = '0,
  parameter  int                      RESET_MODE    = 0,
  parameter  int                      STABLE_CYCLES = 4,
  parameter  int                      GAP_CYCLES    = 3,
  parameter  int                      LOCK_MASK     = 16,
  parameter  int                      LOCK_TIMEOUT  = 65535,
  localparam int                      MW            = $clog2(NUM_MODES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [MW-1:0]               mode_req,
  pll_mode_sequencer_if.master        mgmt,
  input  logic                        pll_locked,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [MW-1:0]               cur_mode
);

  // A zero gap still spends one idle cycle so that the strobe always drops.
  localparam int            GW           = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST     = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam int            LW           = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] MASK_END     = LW'(LOCK_MASK);
  localparam logic [MW-1:0] RESET_MODE_C = MW'(RESET_MODE);

  logic [MW-1:0]     target;
  logic [31:0]       frac_word;
  logic              wr_accept;

  seq_state_e        state_q, state_d;
  seq_state_e        next_wr_q, next_wr_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [MW-1:0]     active_mode_q, active_mode_d;
  logic [MW-1:0]     cur_mode_q, cur_mode_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        lock_sync_q, lock_sync_d;

  pll_req_filter #(
    .NUM_MODES     (NUM_MODES),
    .RESET_MODE    (RESET_MODE),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_req_filter (
    .clk      (clk),
    .reset    (reset),
    .mode_req (mode_req),
    .target   (target)
  );

  assign frac_word = FRAC_TABLE[{active_mode_q, 5'd0} +: 32];

  always_comb begin
    state_d       = state_q;
    next_wr_d     = next_wr_q;
    gap_cnt_d     = gap_cnt_q;
    lock_cnt_d    = lock_cnt_q;
    active_mode_d = active_mode_q;
    cur_mode_d    = cur_mode_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    lock_sync_d   = {lock_sync_q[0], pll_locked};
    wr_accept     = wr_q && !mgmt.mgmt_waitrequest;

    case (state_q)
      S_IDLE: begin
        // Target is only sampled here, so requests arriving mid-sequence
        // collapse to the latest one once the current sequence ends.
        if (target != cur_mode_q) begin
          state_d       = S_WR_MODE;
          active_mode_d = target;
          busy_d        = 1'b1;
          wr_d          = 1'b1;
          addr_d        = ADDR_MODE;
          wdata_d       = '0;
        end
      end

      S_WR_MODE, S_WR_FRAC: begin
        if (wr_accept) begin
          wr_d      = 1'b0;
          gap_cnt_d = '0;
          state_d   = S_GAP;
          next_wr_d = (state_q == S_WR_MODE) ? S_WR_FRAC : S_WR_START;
        end
      end

      S_WR_START: begin
        if (wr_accept) begin
          wr_d       = 1'b0;
          lock_cnt_d = '0;
          state_d    = S_WAIT_LOCK;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = next_wr_q;
          wr_d    = 1'b1;
          addr_d  = write_addr(next_wr_q);
          wdata_d = (next_wr_q == S_WR_FRAC) ? frac_word : 32'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      S_WAIT_LOCK: begin
        // Lock takes priority over timeout so done and error never coincide.
        if (lock_cnt_q >= MASK_END && lock_sync_q[1]) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cur_mode_d = active_mode_q;
          state_d    = S_IDLE;
        end else if (lock_cnt_q >= LOCK_LAST) begin
          error_d    = 1'b1;
          busy_d     = 1'b0;
          cur_mode_d = active_mode_q;
          state_d    = S_IDLE;
        end else if (lock_cnt_q != '1) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      next_wr_q     <= S_WR_FRAC;
      gap_cnt_q     <= '0;
      lock_cnt_q    <= '0;
      active_mode_q <= RESET_MODE_C;
      cur_mode_q    <= RESET_MODE_C;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      lock_sync_q   <= '0;
    end else begin
      state_q       <= state_d;
      next_wr_q     <= next_wr_d;
      gap_cnt_q     <= gap_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      active_mode_q <= active_mode_d;
      cur_mode_q    <= cur_mode_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      lock_sync_q   <= lock_sync_d;
    end
  end

  assign mgmt.mgmt_write     = wr_q;
  assign mgmt.mgmt_address   = addr_q;
  assign mgmt.mgmt_writedata = wdata_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign cur_mode            = cur_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_mode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pll_mode_sequencer                                                      |
// | Directed self-checking bench: a table of full retune sequences plus        |
// | hand-written glitch, out-of-range, mid-sequence and reset-in-gap cases.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pll_mode_sequencer;
  import pll_seq_pkg::*;

  localparam int NM     = 3;
  localparam int MW     = 2;
  localparam int STABLE = 4;
  localparam int GAP    = 3;
  localparam int MASK   = 16;
  localparam int TOUT   = 100;
  localparam logic [NM*32-1:0] FRAC = {32'd2748778984, 32'd2977614927, 32'd3639383488};

  logic          clk;
  logic          reset;
  logic [MW-1:0] mode_req;
  logic          pll_locked;
  logic          busy;
  logic          done;
  logic          error;
  logic [MW-1:0] cur_mode;

  pll_mode_sequencer_if mgmt ();

  pll_mode_sequencer #(
    .NUM_MODES     (NM),
    .FRAC_TABLE    (FRAC),
    .RESET_MODE    (0),
    .STABLE_CYCLES (STABLE),
    .GAP_CYCLES    (GAP),
    .LOCK_MASK     (MASK),
    .LOCK_TIMEOUT  (TOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_req   (mode_req),
    .mgmt       (mgmt.master),
    .pll_locked (pll_locked),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cur_mode   (cur_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [31:0] frac_of [NM];

  always @(posedge clk) begin
    if (mgmt.mgmt_write && !mgmt.mgmt_waitrequest) acc_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) at negedges until the write strobe is seen; n = negedges waited.
  task automatic wait_write(output int n);
    n = 0;
    while (!mgmt.mgmt_write && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge where the strobe is high; stalls for 'stall' cycles.
  task automatic expect_write(input string tag, input logic [5:0] a, input logic [31:0] d,
                              input int stall);
    check({tag, "_strobe"}, mgmt.mgmt_write, 1);
    check({tag, "_addr"}, mgmt.mgmt_address, a);
    check({tag, "_data"}, mgmt.mgmt_writedata, d);
    mgmt.mgmt_waitrequest = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold_strobe"}, mgmt.mgmt_write, 1);
      check({tag, "_hold_addr"}, mgmt.mgmt_address, a);
      check({tag, "_hold_data"}, mgmt.mgmt_writedata, d);
      if (i == stall - 1) mgmt.mgmt_waitrequest = 1'b0;
    end
    @(negedge clk);
    check({tag, "_drop"}, mgmt.mgmt_write, 0);
  endtask

  // One full retune. Lock is driven high at negedges k in [lock_on, lock_off)
  // counted from the first WAIT_LOCK cycle (lock_off = 0 means held).
  task automatic run_seq(input int req, input int stall, input int lock_on, input int lock_off,
                         input int exp_lat, input int mid_req, input bit exp_err, input int exp_n);
    int n;
    int acc0;
    acc0 = acc_cnt;
    mode_req = 2'(req);
    wait_write(n);
    check("latency", n, exp_lat);
    check("busy_start", busy, 1);
    expect_write("wr_mode", ADDR_MODE, 32'd0, 0);
    wait_write(n);
    check("gap1", n, GAP);
    if (mid_req >= 0) mode_req = 2'(mid_req);
    expect_write("wr_frac", ADDR_FRAC, frac_of[req], stall);
    wait_write(n);
    check("gap2", n, GAP);
    expect_write("wr_start", ADDR_START, 32'd0, 0);
    check("busy_wait", busy, 1);
    n = 0;
    while (!done && !error && n < TOUT + 50) begin
      pll_locked = (n >= lock_on) && (lock_off == 0 || n < lock_off);
      @(negedge clk);
      n++;
    end
    pll_locked = 1'b0;
    check("lock_cycles", n, exp_n);
    check("done", done, !exp_err);
    check("error", error, exp_err);
    check("busy_end", busy, 0);
    check("cur_mode", cur_mode, req);
    check("accepted_writes", acc_cnt - acc0, 3);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("error_pulse", error, 0);
  endtask

  typedef struct {
    int req;
    int stall;
    int lock_on;
    int lock_off;
    bit exp_err;
    int exp_n;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wr_seen;
    int busy_seen;

    frac_of[0] = 32'd3639383488;
    frac_of[1] = 32'd2977614927;
    frac_of[2] = 32'd2748778984;

    // Lock at k=20 -> seen 3 cycles later; lock inside the mask is deferred
    // to cycle MASK+1; a lock pulse inside the mask only -> timeout at TOUT.
    vecs[0] = '{req: 1, stall: 0, lock_on: 20, lock_off: 0, exp_err: 1'b0, exp_n: 23};
    vecs[1] = '{req: 2, stall: 5, lock_on: 2,  lock_off: 0, exp_err: 1'b0, exp_n: 17};
    vecs[2] = '{req: 0, stall: 0, lock_on: 2,  lock_off: 8, exp_err: 1'b1, exp_n: 100};
    vecs[3] = '{req: 1, stall: 1, lock_on: 30, lock_off: 0, exp_err: 1'b0, exp_n: 33};

    reset = 1'b1;
    mode_req = 2'd0;
    pll_locked = 1'b0;
    mgmt.mgmt_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_write", mgmt.mgmt_write, 0);
    check("rst_addr", mgmt.mgmt_address, 0);
    check("rst_data", mgmt.mgmt_writedata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cur_mode", cur_mode, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Two-cycle glitch 0->2->0, then an out-of-range request held long.
    wr_seen = 0;
    busy_seen = 0;
    mode_req = 2'd2;
    repeat (2) @(negedge clk);
    mode_req = 2'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mgmt.mgmt_write) wr_seen++;
      if (busy) busy_seen++;
    end
    check("glitch_writes", wr_seen, 0);
    check("glitch_busy", busy_seen, 0);
    mode_req = 2'd3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mgmt.mgmt_write) wr_seen++;
      if (busy) busy_seen++;
    end
    check("range_writes", wr_seen, 0);
    check("range_busy", busy_seen, 0);
    check("range_cur_mode", cur_mode, 0);
    mode_req = 2'd0;
    repeat (10) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_seq(vecs[v].req, vecs[v].stall, vecs[v].lock_on, vecs[v].lock_off,
              2 + STABLE + 1, -1, vecs[v].exp_err, vecs[v].exp_n);
      repeat (5) @(negedge clk);
    end

    // Request 2, switch to 1 during the frac write: 2 completes, 1 follows at once.
    run_seq(2, 0, 20, 0, 2 + STABLE + 1, 1, 1'b0, 23);
    run_seq(1, 0, 20, 0, 0, -1, 1'b0, 23);
    repeat (10) @(negedge clk);
    check("mid_final_mode", cur_mode, 1);

    // Reset while in the gap after the first write.
    mode_req = 2'd2;
    wait_write(n);
    check("rg_latency", n, 2 + STABLE + 1);
    expect_write("rg_mode", ADDR_MODE, 32'd0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rg_write", mgmt.mgmt_write, 0);
    check("rg_busy", busy, 0);
    check("rg_cur_mode", cur_mode, 0);
    check("rg_addr", mgmt.mgmt_address, 0);
    check("rg_data", mgmt.mgmt_writedata, 0);
    reset = 1'b0;
    run_seq(2, 0, 20, 0, 2 + STABLE + 1, -1, 1'b0, 23);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
